// File: rtl/add_serial_pkg.sv
// Shared types and defaults for the serial-adder operand sequencer.
// Holds the FSM state type, default widths/latency and a counter-load helper.
package add_serial_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int LAT_DEF    = 10;
  localparam int ERR_W_DEF  = 8;

  // Wait counter is sized for the full legal latency range (1..255).
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_e;

  // The counter is loaded in LOAD and sampled when it reaches zero,
  // so LAT-1 gives exactly LAT cycles between add_en and the sample.
  function automatic logic [CNT_W-1:0] lat_init(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/add_err_counter.sv
// Saturating mismatch counter; clr has priority over inc.
// Ports: clk, rst (sync, high), inc_i, clr_i, cnt_o[ERR_W].
module add_err_counter #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [ERR_W-1:0] cnt_o
);

  logic [ERR_W-1:0] cnt_q;
  logic [ERR_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {ERR_W{1'b1}})) begin
      cnt_d = cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/add_serial_seq.sv
// Operand sequencer in front of the serial adder: accepts a pair, pulses
// add_en, waits LAT cycles, samples add_out, checks it against a+b and
// hands the result downstream.
// Ports: clk, rst (sync, high); in_valid/in_ready/in_a/in_b upstream;
// add_a/add_b/add_en/add_out to the adder; res_valid/res_ready/res_data/
// res_err downstream; err_cnt/err_clr saturating mismatch count.
module add_serial_seq
  import add_serial_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LAT    = LAT_DEF,
  parameter int ERR_W  = ERR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] add_a,
  output logic [DATA_W-1:0] add_b,
  output logic              add_en,
  input  logic [DATA_W-1:0] add_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err,
  output logic [ERR_W-1:0]  err_cnt,
  input  logic              err_clr
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic              rv_q, rv_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              re_q, re_d;

  // Reference sum keeps the carry, but only the low bits are compared.
  logic [DATA_W:0] sum_full;
  logic            mis;
  logic            sample;

  assign sum_full = {1'b0, op_a_q} + {1'b0, op_b_q};
  assign mis      = add_out != sum_full[DATA_W-1:0];
  assign sample   = (state_q == WAIT) && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      re_q    <= re_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    rv_d    = rv_q;
    rd_d    = rd_q;
    re_d    = re_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_a_d  = in_a;
          op_b_d  = in_b;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = lat_init(LAT);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rd_d    = add_out;
          re_d    = mis;
          rv_d    = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (rv_q && res_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    add_en   = 1'b0;
    unique case (state_q)
      IDLE:    in_ready = 1'b1;
      LOAD:    add_en   = 1'b1;
      WAIT:    ;
      HOLD:    ;
      default: ;
    endcase
  end

  // Operands are left in place after completion so the adder
  // inputs stay quiet until the next accepted pair.
  assign add_a     = op_a_q;
  assign add_b     = op_b_q;
  assign res_valid = rv_q;
  assign res_data  = rd_q;
  assign res_err   = re_q;

  add_err_counter #(
    .ERR_W (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (sample && mis),
    .clr_i (err_clr),
    .cnt_o (err_cnt)
  );

endmodule

// File: tb/tb_add_serial_seq.sv
// Scoreboard bench for add_serial_seq with a behavioural adder model.
// Modes: 0 correct adder, 1 stub (01+01 -> AA), 2 off-by-one.
module tb_add_serial_seq;

  localparam int LAT = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic       add_en;
  logic [7:0] add_out;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_err;
  logic [7:0] err_cnt;
  logic       err_clr;

  typedef struct {
    logic [7:0] d;
    logic       e;
  } exp_t;

  exp_t sb[$];
  int   mode;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_acc = -100;
  int   acc_cnt = 0;
  bit   chk_period = 0;
  bit   rv_prev = 0;

  always #5 clk = ~clk;

  add_serial_seq #(
    .DATA_W (8),
    .LAT    (LAT),
    .ERR_W  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_en    (add_en),
    .add_out   (add_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] adder_fn(input int m, input logic [7:0] a,
                                          input logic [7:0] b);
    case (m)
      1:       return (a == 8'h01 && b == 8'h01) ? 8'hAA : a + b;
      2:       return a + b + 8'd1;
      default: return a + b;
    endcase
  endfunction

  always_comb add_out = adder_fn(mode, add_a, add_b);

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: add_en timing, result latency, scoreboard push/pop.
  always @(negedge clk) begin
    exp_t       e;
    logic [8:0] s;
    if (rst) begin
      rv_prev = 1'b0;
    end else begin
      check("add_en", add_en, cyc == last_acc);
      if (res_valid && !rv_prev) check("latency", cyc - last_acc, LAT + 1);
      rv_prev = res_valid;
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          check("sb_empty", 1, 0);
        end else begin
          e = sb.pop_front();
          check("res_data", res_data, e.d);
          check("res_err", res_err, e.e);
        end
      end
      if (in_valid && in_ready) begin
        s   = {1'b0, in_a} + {1'b0, in_b};
        e.d = adder_fn(mode, in_a, in_b);
        e.e = e.d != s[7:0];
        sb.push_back(e);
        if (chk_period && acc_cnt > 0) check("period", cyc + 1 - last_acc, LAT + 3);
        last_acc = cyc + 1;
        acc_cnt++;
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    bit ok;
    ok = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_rv();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (res_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("rv_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    res_ready = 1'b1;
    err_clr   = 1'b0;
    mode      = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_add_en", add_en, 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_err", res_err, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_in_ready", in_ready, 1);

    // Basic sum.
    send(8'h03, 8'h05);
    wait_idle();
    check("t1_err_cnt", err_cnt, 0);

    // Carry discarded; back-to-back accepts every LAT+3 cycles.
    chk_period = 1;
    acc_cnt    = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_a     = 8'hFF;
    in_b     = 8'h01;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (acc_cnt >= 4) break;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("b2b_count", acc_cnt >= 4, 1);
    wait_idle();
    chk_period = 0;
    check("b2b_err_cnt", err_cnt, 0);

    // Decoy adder output.
    mode = 1;
    send(8'h01, 8'h01);
    wait_idle();
    check("stub_err_cnt", err_cnt, 1);
    mode = 0;

    // Downstream stall.
    res_ready = 1'b0;
    send(8'h12, 8'h34);
    wait_rv();
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_a     = 8'h55;
    in_b     = 8'h66;
    repeat (5) begin
      @(negedge clk);
      check("hold_rv", res_valid, 1);
      check("hold_data", res_data, 8'h46);
      check("hold_err", res_err, 0);
      check("hold_in_ready", in_ready, 0);
      check("hold_add_a", add_a, 8'h12);
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rel_rv", res_valid, 0);
    check("rel_in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_idle();

    // Saturation.
    mode = 2;
    for (int i = 0; i < 300; i++) send(8'(i), 8'h10);
    wait_idle();
    check("sat_err_cnt", err_cnt, 8'hFF);

    // Clear on the sample cycle beats the increment.
    send(8'h20, 8'h02);
    repeat (LAT) @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    check("clr_err_cnt", err_cnt, 0);
    check("clr_rv", res_valid, 1);
    wait_idle();
    send(8'h21, 8'h02);
    wait_idle();
    check("post_clr_cnt", err_cnt, 1);

    // Reset while waiting (counter at 4).
    mode = 0;
    send(8'h77, 8'h11);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    last_acc = -100;
    @(negedge clk);
    check("mid_add_en", add_en, 0);
    check("mid_res_valid", res_valid, 0);
    check("mid_add_a", add_a, 0);
    check("mid_in_ready", in_ready, 1);
    check("mid_err_cnt", err_cnt, 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    check("stale_result", seen, 0);
    check("sb_left", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
